// File: rtl/rs_slot_alloc.sv
// Reservation-station row allocator: grants up to SS_SIZE rows per cycle, all-or-nothing.
// Grants are combinational against the registered bitmap; frees land next edge; callers throttle on num_can_dispatch/rs_full.
module rs_slot_alloc #(
   parameter int RS_SIZE = 16,
   parameter int SS_SIZE = 3,
   parameter int NUM_FU  = 8,
   parameter int IDX_W   = $clog2(RS_SIZE)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [SS_SIZE-1:0]         dispatch_req,
   output logic                       alloc_gnt,
   output logic [SS_SIZE-1:0]         alloc_valid,
   output logic [SS_SIZE*IDX_W-1:0]   alloc_idx,
   input  logic [NUM_FU-1:0]          free_valid,
   input  logic [NUM_FU*IDX_W-1:0]    free_idx,
   input  logic                       flush,
   output logic [IDX_W:0]             free_cnt,
   output logic [$clog2(SS_SIZE):0]   num_can_dispatch,
   output logic                       rs_full,
   output logic [RS_SIZE-1:0]         busy_vec,
   output logic                       err_double_free
);

   localparam int CNT_W = IDX_W + 1;
   localparam int NCD_W = $clog2(SS_SIZE) + 1;

   int                      req_n;
   int                      busy_pop;
   logic [SS_SIZE*IDX_W-1:0] way_idx;
   logic [RS_SIZE-1:0]      pick_mask;
   logic [RS_SIZE-1:0]      alloc_mask;
   logic [RS_SIZE-1:0]      free_mask;
   logic [RS_SIZE-1:0]      busy_next;
   logic                    dbl_free;
   logic [CNT_W-1:0]        free_cnt_next;
   logic [NCD_W-1:0]        ncd_next;
   logic                    rs_full_next;

   always_comb begin
      req_n = 0;
      for (int i = 0; i < SS_SIZE; i++) begin
         if (dispatch_req[i]) req_n = req_n + 1;
      end
   end

   assign alloc_gnt   = (req_n <= int'(free_cnt)) && !flush && !reset;
   assign alloc_valid = dispatch_req & {SS_SIZE{alloc_gnt}};
   assign alloc_idx   = alloc_gnt ? way_idx : '0;
   assign alloc_mask  = alloc_gnt ? pick_mask : '0;

   // Ways claim rows in ascending order; each claim hides the row from later ways.
   always_comb begin : pick_rows
      logic [RS_SIZE-1:0] taken;
      logic               found;
      taken   = busy_vec;
      found   = 1'b0;
      way_idx = '0;
      for (int i = 0; i < SS_SIZE; i++) begin
         found = 1'b0;
         if (dispatch_req[i]) begin
            for (int r = 0; r < RS_SIZE; r++) begin
               if (!found && !taken[r]) begin
                  found                     = 1'b1;
                  taken[r]                  = 1'b1;
                  way_idx[i*IDX_W +: IDX_W] = IDX_W'(r);
               end
            end
         end
      end
      pick_mask = taken & ~busy_vec;
   end

   always_comb begin
      free_mask = '0;
      dbl_free  = 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
         if (free_valid[k]) begin
            free_mask[free_idx[k*IDX_W +: IDX_W]] = 1'b1;
            if (!busy_vec[free_idx[k*IDX_W +: IDX_W]] && !alloc_mask[free_idx[k*IDX_W +: IDX_W]])
               dbl_free = 1'b1;
         end
      end
   end

   // Counts are rederived from the bitmap each cycle so they can never drift from it.
   always_comb begin
      busy_next = flush ? '0 : ((busy_vec & ~free_mask) | alloc_mask);
      busy_pop  = 0;
      for (int r = 0; r < RS_SIZE; r++) begin
         if (busy_next[r]) busy_pop = busy_pop + 1;
      end
      free_cnt_next = CNT_W'(RS_SIZE - busy_pop);
      rs_full_next  = int'(free_cnt_next) < SS_SIZE;
      ncd_next      = rs_full_next ? NCD_W'(free_cnt_next) : NCD_W'(SS_SIZE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_vec         <= '0;
         free_cnt         <= CNT_W'(RS_SIZE);
         num_can_dispatch <= NCD_W'(SS_SIZE);
         rs_full          <= 1'b0;
         err_double_free  <= 1'b0;
      end else begin
         busy_vec         <= busy_next;
         free_cnt         <= free_cnt_next;
         num_can_dispatch <= ncd_next;
         rs_full          <= rs_full_next;
         err_double_free  <= err_double_free | dbl_free;
      end
   end

endmodule

// File: tb/tb_rs_slot_alloc.sv
// Directed bench for rs_slot_alloc with the default 16-row, 3-way, 8-port configuration.
module tb_rs_slot_alloc;

   logic        clock;
   logic        reset;
   logic [2:0]  dispatch_req;
   logic        alloc_gnt;
   logic [2:0]  alloc_valid;
   logic [11:0] alloc_idx;
   logic [7:0]  free_valid;
   logic [31:0] free_idx;
   logic        flush;
   logic [4:0]  free_cnt;
   logic [2:0]  num_can_dispatch;
   logic        rs_full;
   logic [15:0] busy_vec;
   logic        err_double_free;

   int checks   = 0;
   int failures = 0;

   rs_slot_alloc dut (
      .clock            (clock),
      .reset            (reset),
      .dispatch_req     (dispatch_req),
      .alloc_gnt        (alloc_gnt),
      .alloc_valid      (alloc_valid),
      .alloc_idx        (alloc_idx),
      .free_valid       (free_valid),
      .free_idx         (free_idx),
      .flush            (flush),
      .free_cnt         (free_cnt),
      .num_can_dispatch (num_can_dispatch),
      .rs_full          (rs_full),
      .busy_vec         (busy_vec),
      .err_double_free  (err_double_free)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      dispatch_req = 3'b000;
      free_valid   = 8'h00;
      free_idx     = 32'h0;
      flush        = 1'b0;
      reset        = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset        = 1'b1;
      dispatch_req = 3'b111;
      tick();
      #1;
      checks++; if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%0b want=0", alloc_gnt); end
      tick();
      idle();
      checks++; if (busy_vec !== 16'h0000) begin failures++; $display("FAIL reset_busy got=%h want=0000", busy_vec); end
      checks++; if (free_cnt !== 5'd16) begin failures++; $display("FAIL reset_free_cnt got=%0d want=16", free_cnt); end
      checks++; if (num_can_dispatch !== 3'd3) begin failures++; $display("FAIL reset_ncd got=%0d want=3", num_can_dispatch); end
      checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b want=0", rs_full); end
      checks++; if (err_double_free !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", err_double_free); end
   endtask

   task automatic test_first_alloc();
      dispatch_req = 3'b111;
      #1;
      checks++; if (alloc_gnt !== 1'b1) begin failures++; $display("FAIL first_gnt got=%0b want=1", alloc_gnt); end
      checks++; if (alloc_valid !== 3'b111) begin failures++; $display("FAIL first_valid got=%b want=111", alloc_valid); end
      checks++; if (alloc_idx !== 12'h210) begin failures++; $display("FAIL first_idx got=%h want=210", alloc_idx); end
      tick();
      idle();
      checks++; if (busy_vec !== 16'h0007) begin failures++; $display("FAIL first_busy got=%h want=0007", busy_vec); end
      checks++; if (free_cnt !== 5'd13) begin failures++; $display("FAIL first_free_cnt got=%0d want=13", free_cnt); end
      checks++; if (num_can_dispatch !== 3'd3) begin failures++; $display("FAIL first_ncd got=%0d want=3", num_can_dispatch); end
      checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL first_full got=%0b want=0", rs_full); end
   endtask

   task automatic test_fill_full();
      for (int n = 0; n < 3; n++) begin
         dispatch_req = 3'b111;
         tick();
      end
      dispatch_req = 3'b011;
      tick();
      idle();
      checks++; if (busy_vec !== 16'h3FFF) begin failures++; $display("FAIL fill14_busy got=%h want=3fff", busy_vec); end
      checks++; if (free_cnt !== 5'd2) begin failures++; $display("FAIL fill14_free_cnt got=%0d want=2", free_cnt); end
      checks++; if (rs_full !== 1'b1) begin failures++; $display("FAIL fill14_full got=%0b want=1", rs_full); end
      checks++; if (num_can_dispatch !== 3'd2) begin failures++; $display("FAIL fill14_ncd got=%0d want=2", num_can_dispatch); end
      dispatch_req = 3'b111;
      #1;
      checks++; if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL over_gnt got=%0b want=0", alloc_gnt); end
      checks++; if (alloc_valid !== 3'b000) begin failures++; $display("FAIL over_valid got=%b want=000", alloc_valid); end
      checks++; if (alloc_idx !== 12'h000) begin failures++; $display("FAIL over_idx got=%h want=000", alloc_idx); end
      tick();
      checks++; if (busy_vec !== 16'h3FFF) begin failures++; $display("FAIL over_busy got=%h want=3fff", busy_vec); end
      dispatch_req = 3'b011;
      #1;
      checks++; if (alloc_gnt !== 1'b1) begin failures++; $display("FAIL last2_gnt got=%0b want=1", alloc_gnt); end
      checks++; if (alloc_idx !== 12'h0FE) begin failures++; $display("FAIL last2_idx got=%h want=0fe", alloc_idx); end
      tick();
      idle();
      checks++; if (free_cnt !== 5'd0) begin failures++; $display("FAIL full_free_cnt got=%0d want=0", free_cnt); end
      checks++; if (busy_vec !== 16'hFFFF) begin failures++; $display("FAIL full_busy got=%h want=ffff", busy_vec); end
      checks++; if (num_can_dispatch !== 3'd0) begin failures++; $display("FAIL full_ncd got=%0d want=0", num_can_dispatch); end
      #1;
      checks++; if (alloc_gnt !== 1'b1) begin failures++; $display("FAIL full_noreq_gnt got=%0b want=1", alloc_gnt); end
      checks++; if (alloc_valid !== 3'b000) begin failures++; $display("FAIL full_noreq_valid got=%b want=000", alloc_valid); end
   endtask

   task automatic test_free_then_alloc();
      free_valid   = 8'h01;
      free_idx     = 32'h0000_0007;
      dispatch_req = 3'b001;
      #1;
      checks++; if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL samecyc_gnt got=%0b want=0", alloc_gnt); end
      tick();
      free_valid = 8'h00;
      free_idx   = 32'h0;
      checks++; if (free_cnt !== 5'd1) begin failures++; $display("FAIL freed7_free_cnt got=%0d want=1", free_cnt); end
      checks++; if (busy_vec !== 16'hFF7F) begin failures++; $display("FAIL freed7_busy got=%h want=ff7f", busy_vec); end
      #1;
      checks++; if (alloc_gnt !== 1'b1) begin failures++; $display("FAIL reuse7_gnt got=%0b want=1", alloc_gnt); end
      checks++; if (alloc_idx !== 12'h007) begin failures++; $display("FAIL reuse7_idx got=%h want=007", alloc_idx); end
      tick();
      idle();
      checks++; if (free_cnt !== 5'd0) begin failures++; $display("FAIL reuse7_free_cnt got=%0d want=0", free_cnt); end
   endtask

   task automatic test_skip_way();
      free_valid = 8'h03;
      free_idx   = 32'h0000_0052;
      tick();
      idle();
      checks++; if (busy_vec !== 16'hFFDB) begin failures++; $display("FAIL free25_busy got=%h want=ffdb", busy_vec); end
      dispatch_req = 3'b101;
      #1;
      checks++; if (alloc_valid !== 3'b101) begin failures++; $display("FAIL skip_valid got=%b want=101", alloc_valid); end
      checks++; if (alloc_idx !== 12'h502) begin failures++; $display("FAIL skip_idx got=%h want=502", alloc_idx); end
      tick();
      idle();
      checks++; if (busy_vec !== 16'hFFFF) begin failures++; $display("FAIL skip_busy got=%h want=ffff", busy_vec); end
   endtask

   task automatic test_double_free();
      free_valid = 8'h03;
      free_idx   = 32'h0000_0044;
      tick();
      idle();
      checks++; if (free_cnt !== 5'd1) begin failures++; $display("FAIL dup_free_cnt got=%0d want=1", free_cnt); end
      checks++; if (err_double_free !== 1'b0) begin failures++; $display("FAIL dup_err got=%0b want=0", err_double_free); end
      free_valid = 8'h01;
      free_idx   = 32'h0000_0004;
      tick();
      idle();
      checks++; if (err_double_free !== 1'b1) begin failures++; $display("FAIL dbl_err got=%0b want=1", err_double_free); end
      checks++; if (busy_vec !== 16'hFFEF) begin failures++; $display("FAIL dbl_busy got=%h want=ffef", busy_vec); end
      flush = 1'b1;
      tick();
      idle();
      checks++; if (err_double_free !== 1'b1) begin failures++; $display("FAIL dbl_sticky got=%0b want=1", err_double_free); end
      checks++; if (free_cnt !== 5'd16) begin failures++; $display("FAIL dbl_flush_cnt got=%0d want=16", free_cnt); end
   endtask

   task automatic test_flush();
      for (int n = 0; n < 3; n++) begin
         dispatch_req = 3'b111;
         tick();
      end
      dispatch_req = 3'b001;
      tick();
      idle();
      checks++; if (busy_vec !== 16'h03FF) begin failures++; $display("FAIL ten_busy got=%h want=03ff", busy_vec); end
      checks++; if (free_cnt !== 5'd6) begin failures++; $display("FAIL ten_free_cnt got=%0d want=6", free_cnt); end
      flush        = 1'b1;
      dispatch_req = 3'b111;
      free_valid   = 8'h01;
      free_idx     = 32'h0;
      #1;
      checks++; if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL flush_gnt got=%0b want=0", alloc_gnt); end
      checks++; if (alloc_valid !== 3'b000) begin failures++; $display("FAIL flush_valid got=%b want=000", alloc_valid); end
      tick();
      idle();
      checks++; if (busy_vec !== 16'h0000) begin failures++; $display("FAIL flush_busy got=%h want=0000", busy_vec); end
      checks++; if (free_cnt !== 5'd16) begin failures++; $display("FAIL flush_free_cnt got=%0d want=16", free_cnt); end
      checks++; if (num_can_dispatch !== 3'd3) begin failures++; $display("FAIL flush_ncd got=%0d want=3", num_can_dispatch); end
      checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL flush_full got=%0b want=0", rs_full); end
   endtask

   task automatic test_reset_mid();
      for (int n = 0; n < 2; n++) begin
         dispatch_req = 3'b111;
         tick();
      end
      idle();
      checks++; if (free_cnt !== 5'd10) begin failures++; $display("FAIL mid_free_cnt got=%0d want=10", free_cnt); end
      reset        = 1'b1;
      dispatch_req = 3'b111;
      #1;
      checks++; if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL mid_reset_gnt got=%0b want=0", alloc_gnt); end
      tick();
      idle();
      checks++; if (busy_vec !== 16'h0000) begin failures++; $display("FAIL mid_reset_busy got=%h want=0000", busy_vec); end
      checks++; if (free_cnt !== 5'd16) begin failures++; $display("FAIL mid_reset_free_cnt got=%0d want=16", free_cnt); end
      checks++; if (err_double_free !== 1'b0) begin failures++; $display("FAIL mid_reset_err got=%0b want=0", err_double_free); end
      checks++; if (num_can_dispatch !== 3'd3) begin failures++; $display("FAIL mid_reset_ncd got=%0d want=3", num_can_dispatch); end
   endtask

   initial begin
      idle();
      test_reset();
      test_first_alloc();
      test_fill_full();
      test_free_then_alloc();
      test_skip_way();
      test_double_free();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs_slot_alloc.md
Name: rs_slot_alloc

Overview:
- Entry-allocation controller for the 3-way reservation station.
- Owns the free/busy bitmap of RS rows and grants row indices to up to SS_SIZE dispatching instructions per cycle.
- Reclaims rows released by the issue logic and clears everything on a pipeline flush.
- Publishes registered occupancy and credit signals so decode dispatches only what the RS can accept.

Parameters:
RS_SIZE, 16, number of RS rows; power of two, minimum 4.
SS_SIZE, 3, dispatch ways per cycle.
NUM_FU, 8, issue ports that can free a row per cycle.
IDX_W, $clog2(RS_SIZE), row index width (derived).

Ports:
clock  in  1  system clock, all state updates on posedge.
reset  in  1  synchronous, active-high; takes effect at the posedge where it is sampled high.
dispatch_req  in  SS_SIZE  per-way request; bit i = way i wants a row.
alloc_gnt  out  1  combinational; 1 = every requesting way is granted this cycle.
alloc_valid  out  SS_SIZE  combinational; per-way grant = dispatch_req & {SS_SIZE{alloc_gnt}}.
alloc_idx  out  SS_SIZE x IDX_W  combinational; row assigned to each way, 0 when not granted.
free_valid  in  NUM_FU  per-issue-port release strobe.
free_idx  in  NUM_FU x IDX_W  row released by each port.
flush  in  1  branch-mispredict squash; all rows freed.
free_cnt  out  IDX_W+1  registered count of free rows.
num_can_dispatch  out  $clog2(SS_SIZE)+1  registered min(free_cnt, SS_SIZE).
rs_full  out  1  registered; 1 when free_cnt < SS_SIZE.
busy_vec  out  RS_SIZE  registered bitmap; 1 = row occupied.
err_double_free  out  1  sticky; set when a free targets a row that is already free.

Behaviour:
- State: busy_vec[RS_SIZE-1:0], free_cnt, num_can_dispatch, rs_full, err_double_free. All are registers; no FSM beyond the bitmap.
- Reset outputs: busy_vec=0, free_cnt=RS_SIZE, num_can_dispatch=SS_SIZE, rs_full=0, err_double_free=0.
- Allocation, combinational, zero latency:
  - req_n = popcount(dispatch_req).
  - alloc_gnt = (req_n <= free_cnt) & !flush & !reset.
  - The grant is all-or-nothing. A partial grant is never given; on req_n > free_cnt nothing is allocated.
  - Requesting ways are served in ascending way order. Each takes the next lowest-indexed row whose busy_vec bit is 0.
  - Non-requesting ways are skipped and do not consume a row. Example: req=3'b101 with rows 2 and 5 free gives way0=2, way2=5.
- Release:
  - Each free_valid[k] clears busy_vec[free_idx[k]] at the next posedge.
  - Duplicate free_idx values in one cycle clear the row once and count once.
  - Free of a row with busy_vec bit 0 (and not being allocated the same cycle) sets err_double_free; the bitmap is unaffected.
- Same-cycle ordering:
  - Rows freed in cycle t are NOT visible to allocation until cycle t+1, because allocation reads the registered busy_vec.
  - The allocator never picks a busy row, so alloc and free never target the same row.
- Next state:
  - busy_next = (busy_vec & ~free_mask) | alloc_mask.
  - free_cnt_next = RS_SIZE - popcount(busy_next), computed from the bitmap, not incrementally, so it cannot drift.
  - num_can_dispatch and rs_full are computed from free_cnt_next and registered. They are consistent with free_cnt every cycle.
- Flush: busy_next = 0 and free_cnt_next = RS_SIZE. Flush overrides same-cycle alloc and free; alloc_gnt is forced to 0. err_double_free is not cleared by flush.
- Reset mid-operation: all state returns to reset values at that edge, and alloc_gnt=0 during the reset cycle. err_double_free is cleared only by reset.
- Full: free_cnt=0 gives alloc_gnt=0 for any nonzero request. With dispatch_req=0, alloc_gnt=1 and alloc_valid=0 (trivially satisfied).
- Widths: free_cnt holds 0..RS_SIZE inclusive, hence IDX_W+1 bits.

Test Plan:
- Reset then dispatch_req=3'b111 → alloc_gnt=1, alloc_idx={2,1,0} (way2..way0); next cycle busy_vec=16'h0007, free_cnt=13, num_can_dispatch=3, rs_full=0.
- Fill to 14 busy (rows 0..13), dispatch_req=3'b111 → alloc_gnt=0, alloc_valid=0, busy_vec unchanged, rs_full=1, num_can_dispatch=2. Then dispatch_req=3'b011 → grants rows 14 and 15, free_cnt=0.
- Full RS, free_valid[0]=1 with free_idx[0]=7 and dispatch_req=3'b001 in the same cycle → alloc_gnt=0 that cycle. Next cycle the same request is granted row 7 and free_cnt returns to 0.
- Rows 2 and 5 free, dispatch_req=3'b101 → way0=2, way2=5, alloc_valid=3'b101, alloc_idx[1]=0.
- Two ports free row 4 in the same cycle, then free row 4 again a cycle later → first event: free_cnt +1 only, err_double_free=0. Second event: err_double_free=1 and stays 1 through flush.
- 10 rows busy, flush=1 together with dispatch_req=3'b111 and free_valid=1 → alloc_gnt=0. Next cycle busy_vec=0, free_cnt=16. Assert reset mid-fill → same result, err_double_free=0.
